// File: rtl/cla_word_serial_adder_pkg.sv
// Shared types and constants for the word-serial carry-lookahead adder.
package cla_word_serial_adder_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Slice-index width; never below one bit so a single-slice build still has a counter.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/cla_word_serial_adder_if.sv
// Operand/result valid-ready bundle between producer, adder and consumer.
interface cla_word_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cla_word_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; exposes c3 so the caller can derive overflow.
module cla_word_serial_adder_cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c3,
  output logic       c4
);
  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = x & y;
  assign p = x ^ y;

  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
              (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};
endmodule

// File: rtl/cla_word_serial_adder.sv
// Word-serial WIDTH-bit add/subtract: one CLA slice resolves 4 bits per cycle,
// carry registered between slices. WIDTH must be a multiple of 4 and >= 4.
module cla_word_serial_adder
  import cla_word_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  cla_word_serial_adder_if.slave bus
);
  localparam int unsigned N    = WIDTH / SLICE_W;
  localparam int unsigned IdxW = idx_width(N);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_c3;
  logic               slice_c4;

  // Operands shift right each cycle so the active slice always sits in the low bits.
  cla_word_serial_adder_cla4_slice u_slice (
    .x   (a_q[SLICE_W-1:0]),
    .y   (b_q[SLICE_W-1:0]),
    .cin (carry_q),
    .s   (slice_s),
    .c3  (slice_c3),
    .c4  (slice_c4)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
          carry_d = bus.in_sub;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = slice_s;
        carry_d = slice_c4;
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        if (idx_q == IdxW'(N - 1)) begin
          cout_d  = slice_c4;
          ovf_d   = slice_c3 ^ slice_c4;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
endmodule
